// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types for the OTTER memory-port arbiter: FSM states, access owner
// and the fixed size code used for instruction fetches.
package otter;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_F,
        OWN_D
    } arb_owner_t;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/otter_mem_arbiter.sv
// Shares the single OTTER memory port between instruction fetch (F) and
// load/store (D): one access in flight, fixed read latency, D-priority with a streak limit.
module otter_mem_arbiter
    import otter::*;
#(
    parameter int LATENCY         = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output arb_state_t  state,
    output logic [3:0]  streak
);

    localparam logic [2:0] CNT_INIT    = 3'(LATENCY - 1);
    localparam logic [3:0] STREAK_FULL = 4'(MAX_DATA_STREAK);

    arb_owner_t owner;
    logic [2:0] cnt;
    logic       complete;
    logic       issue_ok;
    logic       streak_full;

    // The response cycle is also an issue cycle, so accesses can run back-to-back.
    assign complete    = (state == ARB_WAIT) && (cnt == 3'd0);
    assign issue_ok    = (state == ARB_IDLE) || complete;
    assign streak_full = (streak == STREAK_FULL);

    assign f_gnt  = issue_ok && f_req && (!d_req || streak_full);
    assign d_gnt  = issue_ok && d_req && !f_gnt;
    assign mem_en = f_gnt | d_gnt;
    assign busy   = (state == ARB_WAIT);

    assign f_rvalid = complete && (owner == OWN_F);
    assign d_rvalid = complete && (owner == OWN_D);
    assign f_rdata  = f_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_size  = d_size;
            mem_sign  = d_sign;
        end else if (f_gnt) begin
            mem_addr = f_addr;
            mem_size = MEM_SIZE_WORD;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ARB_IDLE;
            owner  <= OWN_F;
            cnt    <= 3'd0;
            streak <= 4'd0;
        end else begin
            if (f_gnt || d_gnt) begin
                owner <= d_gnt ? OWN_D : OWN_F;
                cnt   <= CNT_INIT;
                state <= ARB_WAIT;
            end else if (state == ARB_WAIT) begin
                if (cnt == 3'd0) begin
                    state <= ARB_IDLE;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end

            // Count D wins that made a waiting F lose; F winning or going idle resets it.
            if (!f_req || f_gnt) begin
                streak <= 4'd0;
            end else if (d_gnt && !streak_full) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: drivers feed per-requester command
// queues, a negedge monitor checks grants and responses against expected queues.
module tb_otter_mem_arbiter;
    import otter::*;

    localparam int LAT  = 3;
    localparam int MAXS = 4;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } gnt_t;

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } d_cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [1:0]  d_size = 2'b00;
    logic        d_sign = 1'b0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we, mem_sign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        busy;
    arb_state_t  state;
    logic [3:0]  streak;

    otter_mem_arbiter #(.LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_sign(d_sign), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata),
        .busy(busy), .state(state), .streak(streak)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_fn = 32'h0000_0013;
            32'h0000_0300: mem_fn = 32'hFFFF_FF80;
            default:       mem_fn = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    logic [32:0] pipe [LAT];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= 33'h0;
        end else begin
            pipe[0] <= {mem_en, mem_addr};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (pipe[LAT-1][32]) mem_rdata = mem_fn(pipe[LAT-1][31:0]);
    end

    // ---------------- scoreboard state ----------------
    int     checks = 0;
    int     errors = 0;
    int     outstanding = 0;
    gnt_t   exp_gnt_q[$];
    rsp_t   exp_rsp_q[$];
    int     gnt_cyc_q[$];
    logic [31:0] f_q[$];
    d_cmd_t d_q[$];
    bit     f_took = 0;
    bit     d_took = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_f(input logic [31:0] a, input logic [31:0] exp_data);
        f_q.push_back(a);
        exp_gnt_q.push_back('{is_d: 1'b0, we: 1'b0, addr: a, wdata: 32'h0, size: 2'b10, sign: 1'b0});
        exp_rsp_q.push_back('{is_d: 1'b0, chk: 1'b1, data: exp_data});
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg, input logic [31:0] exp_data);
        d_q.push_back('{we: we, addr: a, wdata: wd, size: sz, sign: sg});
        exp_gnt_q.push_back('{is_d: 1'b1, we: we, addr: a, wdata: wd, size: sz, sign: sg});
        exp_rsp_q.push_back('{is_d: 1'b1, chk: !we, data: exp_data});
    endtask

    // Requests are held until granted, then the next queued command is presented.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (f_took) begin
                f_took = 0;
                f_req  = 1'b0;
            end
            if (d_took) begin
                d_took = 0;
                d_req  = 1'b0;
            end
            if (!f_req && f_q.size() > 0) begin
                f_addr = f_q.pop_front();
                f_req  = 1'b1;
            end
            if (!d_req && d_q.size() > 0) begin
                d_cmd_t c;
                c = d_q.pop_front();
                d_we = c.we; d_addr = c.addr; d_wdata = c.wdata;
                d_size = c.size; d_sign = c.sign;
                d_req = 1'b1;
            end
        end
    end

    task automatic wait_gnt(input logic want_d, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (want_d ? d_gnt : f_gnt) return;
        end
        fail(name);
    endtask

    task automatic wait_rvalid(input logic want_d, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (want_d ? d_rvalid : f_rvalid) return;
        end
        fail(name);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && !busy) return;
            tick(1);
        end
        fail(name);
    endtask

    // ---------------- monitor ----------------
    gnt_t g;
    rsp_t r;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs", {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, busy}, 96'h0);
            chk("reset_regs", {state == ARB_IDLE, streak}, {1'b1, 4'd0});
            outstanding = 0;
        end else begin
            chk("busy", busy, outstanding > 0);
            chk("mem_en", mem_en, f_gnt | d_gnt);
            if (f_gnt && d_gnt) fail("gnt_both");
            if (!mem_en && mem_we) fail("mem_we_idle");
            if (f_rvalid || d_rvalid) begin
                if (f_rvalid && d_rvalid) fail("rvalid_both");
                if (exp_rsp_q.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_owner", d_rvalid, r.is_d);
                    if (r.chk) chk("rsp_data", r.is_d ? d_rdata : f_rdata, r.data);
                    chk("rsp_other_zero", r.is_d ? f_rdata : d_rdata, 96'h0);
                    if (gnt_cyc_q.size() > 0) chk("rsp_latency", cycle - gnt_cyc_q.pop_front(), LAT);
                end
                if (outstanding > 0) outstanding--;
            end
            if (f_gnt || d_gnt) begin
                if (exp_gnt_q.size() == 0) begin
                    fail("gnt_unexpected");
                end else begin
                    g = exp_gnt_q.pop_front();
                    chk("gnt_bus", {d_gnt, mem_we, mem_addr, mem_wdata, mem_size, mem_sign}, g);
                end
                gnt_cyc_q.push_back(cycle);
                outstanding++;
                if (f_gnt) f_took = 1;
                if (d_gnt) d_took = 1;
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single fetch.
        issue_f(32'h0000_0100, 32'h0000_0013);
        drain("drain_fetch");
        tick(2);

        // Contention: store wins first, fetch issued back-to-back on its completion.
        issue_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0);
        issue_f(32'h0000_0104, 32'h5A5A_0104);
        wait_rvalid(1'b1, "timeout_store_rvalid");
        chk("b2b_f_gnt", f_gnt, 1'b1);
        drain("drain_contention");
        tick(2);

        // Streak limit: D,D,D,D,F,D,D,D,D,F with both requesters saturated.
        for (int i = 0; i < 4; i++)
            issue_d(1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 2'b10, 1'b0, 32'h5A5A_1000 + 32'(4 * i));
        issue_f(32'h0000_0200, 32'h5A5A_0200);
        for (int i = 4; i < 8; i++)
            issue_d(1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 2'b10, 1'b0, 32'h5A5A_1000 + 32'(4 * i));
        issue_f(32'h0000_0204, 32'h5A5A_0204);
        drain("drain_streak");
        tick(2);

        // Signed byte load.
        issue_d(1'b0, 32'h0000_0300, 32'h0, 2'b00, 1'b1, 32'hFFFF_FF80);
        drain("drain_byte_load");
        tick(2);

        // Reset while a fetch is outstanding: the response is dropped.
        issue_f(32'h0000_0600, 32'h5A5A_0600);
        wait_gnt(1'b0, "timeout_rst_gnt");
        tick(1);
        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0;
        f_took = 0; d_took = 0;
        f_q.delete(); d_q.delete();
        exp_gnt_q.delete(); exp_rsp_q.delete(); gnt_cyc_q.delete();
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_streak", streak, 4'd0);
        chk("post_rst_state", state == ARB_IDLE, 1'b1);
        tick(1);
        issue_f(32'h0000_0604, 32'h5A5A_0604);
        begin : wait_req
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (f_req) disable wait_req;
            end
            fail("timeout_post_rst_req");
        end
        chk("post_rst_gnt_now", f_gnt, 1'b1);
        drain("drain_reset");
        tick(2);

        // Fetch pulse during an outstanding load must be ignored.
        issue_d(1'b0, 32'h0000_0400, 32'h0, 2'b10, 1'b0, 32'h5A5A_0400);
        wait_gnt(1'b1, "timeout_pulse_gnt");
        tick(1);
        f_addr = 32'h0000_0500;
        f_req  = 1'b1;
        @(negedge clk);
        chk("pulse_no_gnt", f_gnt, 1'b0);
        chk("pulse_no_mem", mem_en, 1'b0);
        tick(1);
        f_req = 1'b0;
        drain("drain_pulse");
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cycle);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single data/instruction memory port of the multicycle OTTER core between two requesters: instruction fetch (F) and load/store (D).
- Sits between the control FSM/datapath and the Memory block.
- Grants one access at a time and tracks memory read latency.
- Returns read data with a valid strobe to the requester that owns the access.

Parameters:
LATENCY, 1, cycles from issue (mem_en high) to mem_rdata valid; legal range 1..7
MAX_DATA_STREAK, 4, consecutive D grants allowed while F is waiting before F is forced to win; legal range 1..15

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
f_req  input  1  fetch request; held with f_addr until f_gnt
f_addr  input  32  fetch byte address, word aligned
f_gnt  output  1  fetch access issued this cycle
f_rvalid  output  1  f_rdata valid this cycle
f_rdata  output  32  fetched instruction word
d_req  input  1  data request; held with payload until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_size  input  2  00 byte, 01 half, 10 word
d_sign  input  1  load sign-extend
d_gnt  output  1  data access issued this cycle
d_rvalid  output  1  completion; d_rdata valid for loads
d_rdata  output  32  load data
mem_en  output  1  access strobe to memory
mem_we  output  1  write enable to memory
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_size  output  2  memory access size
mem_sign  output  1  memory sign-extend
mem_rdata  input  32  memory read data, valid LATENCY cycles after mem_en
busy  output  1  an access is outstanding

Behaviour:
- Reset (asynchronous, RESET_N low): state IDLE, latency counter 0, streak 0, owner F. All of f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we and busy are 0. Any outstanding access is dropped; no rvalid ever follows it.
- States: IDLE, WAIT.
- Issue is allowed in IDLE, or in WAIT during the cycle the response completes (back-to-back). Throughput is one access per LATENCY cycles.
- Arbitration in an issue-allowed cycle:
  - Only f_req high: F wins.
  - Only d_req high: D wins.
  - Both high: D wins unless streak == MAX_DATA_STREAK, in which case F wins.
- Grant signals: f_gnt/d_gnt are combinational and equal to the win. mem_en = f_gnt | d_gnt.
- Mem bus contents:
  - F grant: mem_addr = f_addr, mem_we = 0, mem_size = 10, mem_sign = 0, mem_wdata = 0.
  - D grant: mem_addr = d_addr, mem_we = d_we, mem_size = d_size, mem_sign = d_sign, mem_wdata = d_wdata.
  - No grant: mem_we = 0.
- On grant:
  - Register owner.
  - Counter = LATENCY − 1.
  - Go to WAIT.
  - busy = 1 from the next cycle.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, assert owner's rvalid for exactly one cycle; that owner's rdata = mem_rdata (combinational pass-through).
  - Then return to IDLE, or stay in WAIT if a new grant is made in that same cycle.
- Non-owner rdata is 0. rvalid is never asserted for both requesters in one cycle.
- Streak rules:
  - Increments on a D grant made while f_req is high; saturates at MAX_DATA_STREAK.
  - Clears on any F grant, and in any cycle f_req is low.
- A request dropped before its grant generates no access. The payload is sampled only in the grant cycle.
- Stores still produce d_rvalid after LATENCY cycles; d_rdata for a store is don't-care.

Decomposition:
- Shared package otter: arb_state_t enum {ARB_IDLE, ARB_WAIT}; arb_owner_t enum {OWN_F, OWN_D}; MEM_SIZE_WORD = 2'b10.
- No sub-module; counter and streak logic stay inline.

Test Plan:
1. Reset, LATENCY=1, f_req with f_addr=0x0000_0100 and mem_rdata=0x0000_0013 -> f_gnt in cycle 0 with mem_addr=0x100; f_rvalid with f_rdata=0x13 in cycle 1; busy is 1 in cycle 1 only.
2. LATENCY=3, f_req and d_req both high, d_we=1, d_addr=0x0000_2000, d_wdata=0xDEADBEEF -> d_gnt first with mem_we=1; d_rvalid 3 cycles later; f_gnt in that same cycle.
3. MAX_DATA_STREAK=4, d_req and f_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F.
4. Load with d_size=00, d_sign=1, LATENCY=2, mem_rdata=0xFFFF_FF80 -> mem_size=00 and mem_sign=1 in the issue cycle; d_rvalid with d_rdata=0xFFFF_FF80 two cycles later; f_rvalid stays 0.
5. LATENCY=4, grant F, assert RESET_N low in cycle 2 and release in cycle 3 -> no f_rvalid; busy=0; streak=0; the next f_req is granted immediately.
6. f_req pulsed high for one cycle while a D access is outstanding (WAIT, not completing) -> no f_gnt and no memory access for that pulse.
